// File: rtl/addition_subtraction.sv
`default_nettype none
// ============================================================================
// Module      : addition_subtraction
// Description : Two-stage pipelined IEEE-754 binary32 adder/subtractor.
//               Define ADDSUB_ROUND_NEAREST_EN for round-to-nearest-even;
//               otherwise results are truncated (round toward zero).
// Revision    : 1.0 - initial release
// ============================================================================

module addition_subtraction (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   input  logic        AddBar_Sub,
   output logic        out_valid,
   output logic        Exception,
   output logic [31:0] result
);

   localparam logic [31:0] c_qnan      = 32'h7FC0_0000;
   localparam logic [7:0]  c_exp_max   = 8'hFF;
   localparam logic [7:0]  c_max_shift = 8'd26;

   // Index of the first set bit counted from bit 26; 27 when v is zero.
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) lzc27 = 5'(26 - i);
      end
   endfunction

   // ------------------------------------------------------------------------
   // Stage 1: decode, swap, align, add/subtract
   // ------------------------------------------------------------------------
   logic        w_b_sign;
   logic        w_special;
   logic [30:0] w_a_mag;
   logic [30:0] w_b_mag;
   logic        w_swap;
   logic [31:0] w_big;
   logic [31:0] w_small;
   logic [23:0] w_big_sig;
   logic [23:0] w_small_sig;
   logic [7:0]  w_exp_diff;
   logic [49:0] w_shift_ext;
   logic [26:0] w_big_ext;
   logic [26:0] w_small_ext;
   logic [27:0] w_sum;

   always_comb begin
      w_b_sign  = b_operand[31] ^ AddBar_Sub;
      w_special = (a_operand[30:23] == c_exp_max) || (b_operand[30:23] == c_exp_max);
      // Subnormals collapse to zero before the magnitude compare.
      w_a_mag   = (a_operand[30:23] == 8'h00) ? 31'd0 : a_operand[30:0];
      w_b_mag   = (b_operand[30:23] == 8'h00) ? 31'd0 : b_operand[30:0];
      w_swap    = (w_b_mag > w_a_mag);
      w_big     = w_swap ? {w_b_sign, w_b_mag} : {a_operand[31], w_a_mag};
      w_small   = w_swap ? {a_operand[31], w_a_mag} : {w_b_sign, w_b_mag};

      w_big_sig   = (w_big[30:23]   == 8'h00) ? 24'd0 : {1'b1, w_big[22:0]};
      w_small_sig = (w_small[30:23] == 8'h00) ? 24'd0 : {1'b1, w_small[22:0]};
      w_exp_diff  = w_big[30:23] - w_small[30:23];

      // Aligned significand followed by guard, round and sticky.
      w_shift_ext = {w_small_sig, 26'd0} >> w_exp_diff;
      if (w_exp_diff >= c_max_shift) begin
         w_small_ext = {26'd0, |w_small_sig};
      end else begin
         w_small_ext = {w_shift_ext[49:24], |w_shift_ext[23:0]};
      end
      w_big_ext = {w_big_sig, 3'b000};

      if (w_big[31] == w_small[31]) begin
         w_sum = {1'b0, w_big_ext} + {1'b0, w_small_ext};
      end else begin
         w_sum = {1'b0, w_big_ext} - {1'b0, w_small_ext};
      end
   end

   logic        r_s1_valid;
   logic        r_s1_special;
   logic        r_s1_sign;
   logic [7:0]  r_s1_exp;
   logic [27:0] r_s1_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_special <= 1'b0;
         r_s1_sign    <= 1'b0;
         r_s1_exp     <= 8'd0;
         r_s1_sum     <= 28'd0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_special <= w_special;
            r_s1_sign    <= w_big[31];
            r_s1_exp     <= w_big[30:23];
            r_s1_sum     <= w_sum;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: normalize, round, exponent adjust, pack
   // ------------------------------------------------------------------------
   logic [4:0]        w_lzc;
   logic [26:0]       w_norm;
   logic signed [9:0] w_exp_norm;
   logic signed [9:0] w_exp_final;
   logic [23:0]       w_mant;
   logic [31:0]       w_result;
   logic              w_exception;
   logic              w_unused_bits;
`ifdef ADDSUB_ROUND_NEAREST_EN
   logic              w_round_up;
   logic [24:0]       w_mant_rnd;
`endif

   always_comb begin
      w_lzc = lzc27(r_s1_sum[26:0]);
      if (r_s1_sum[27]) begin
         // Carry-out: shift right once, folding the lost bit into sticky.
         w_norm     = {r_s1_sum[27:2], r_s1_sum[1] | r_s1_sum[0]};
         w_exp_norm = $signed({2'b00, r_s1_exp}) + 10'sd1;
      end else begin
         w_norm     = r_s1_sum[26:0] << w_lzc;
         w_exp_norm = $signed({2'b00, r_s1_exp}) - $signed({5'd0, w_lzc});
      end

`ifdef ADDSUB_ROUND_NEAREST_EN
      w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
      w_mant_rnd = {1'b0, w_norm[26:3]} + 25'(w_round_up);
      if (w_mant_rnd[24]) begin
         w_mant      = w_mant_rnd[24:1];
         w_exp_final = w_exp_norm + 10'sd1;
      end else begin
         w_mant      = w_mant_rnd[23:0];
         w_exp_final = w_exp_norm;
      end
      w_unused_bits = w_mant[23];
`else
      w_mant        = w_norm[26:3];
      w_exp_final   = w_exp_norm;
      w_unused_bits = ^{w_norm[2:0], w_mant[23]};
`endif

      if (r_s1_special) begin
         w_result    = c_qnan;
         w_exception = 1'b1;
      end else if (r_s1_sum == 28'd0) begin
         w_result    = 32'h0000_0000;
         w_exception = 1'b0;
      end else if (w_exp_final >= 10'sd255) begin
         w_result    = {r_s1_sign, c_exp_max, 23'd0};
         w_exception = 1'b1;
      end else if (w_exp_final <= 10'sd0) begin
         w_result    = {r_s1_sign, 31'd0};
         w_exception = 1'b0;
      end else begin
         w_result    = {r_s1_sign, w_exp_final[7:0], w_mant[22:0]};
         w_exception = 1'b0;
      end
   end

   logic        r_out_valid;
   logic        r_exception;
   logic [31:0] r_result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_exception <= 1'b0;
         r_result    <= 32'd0;
      end else begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_exception <= w_exception;
            r_result    <= w_result;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign Exception = r_exception;
   assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_addition_subtraction.sv
`default_nettype none
// ============================================================================
// Module      : tb_addition_subtraction
// Description : Directed self-checking bench for addition_subtraction.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_addition_subtraction;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a_operand;
   logic [31:0] b_operand;
   logic        AddBar_Sub;
   logic        out_valid;
   logic        Exception;
   logic [31:0] result;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

`ifdef ADDSUB_ROUND_NEAREST_EN
   localparam logic [31:0] c_decay_exp  = 32'h4089_851F;
   localparam logic [31:0] c_sticky_exp = 32'h3F80_0000;
`else
   localparam logic [31:0] c_decay_exp  = 32'h4089_851E;
   localparam logic [31:0] c_sticky_exp = 32'h3F7F_FFFF;
`endif

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          due;
      string       tag;
   } exp_t;

   exp_t sb[$];

   addition_subtraction dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a_operand (a_operand),
      .b_operand (b_operand),
      .AddBar_Sub(AddBar_Sub),
      .out_valid (out_valid),
      .Exception (Exception),
      .result    (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_vec++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp_v);
      end
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] r, input logic x);
      a_operand  = a;
      b_operand  = b;
      AddBar_Sub = sub;
      in_valid   = 1'b1;
      sb.push_back('{r, x, cyc + 2, tag});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 10; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
         #1;
      end
      check("pipeline drained", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            check("spurious out_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.tag, " result"}, result, e.res);
            check({e.tag, " exception"}, {31'd0, Exception}, {31'd0, e.exc});
            check({e.tag, " latency"}, 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      a_operand  = 32'd0;
      b_operand  = 32'd0;
      AddBar_Sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset exception", {31'd0, Exception}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back stream, with one idle gap.
      issue("1+1",        32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0);
      issue("3-1",        32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0);
      issue("decay sum",  32'h4037_5C29, 32'h3FB7_5C29, 1'b0, c_decay_exp,   1'b0);
      issue("cancel",     32'h40B7_5C29, 32'h40B7_5C29, 1'b1, 32'h0000_0000, 1'b0);
      issue("inf in",     32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1);
      issue("overflow",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      issue("1-3 swap",   32'h3F80_0000, 32'h4040_0000, 1'b1, 32'hC000_0000, 1'b0);
      issue("underflow+", 32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0);
      issue("underflow-", 32'h80C0_0000, 32'h0080_0000, 1'b0, 32'h8000_0000, 1'b0);
      issue("subnormal",  32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0);
      issue("sticky sub", 32'h3F80_0000, 32'h3280_0000, 1'b1, c_sticky_exp,  1'b0);
      issue("guard tie",  32'h4B80_0000, 32'h3F80_0000, 1'b0, 32'h4B80_0000, 1'b0);
      issue("nan in",     32'h3F80_0000, 32'h7FC0_0000, 1'b0, 32'h7FC0_0000, 1'b1);
      issue("-2+2",       32'hC000_0000, 32'h4000_0000, 1'b0, 32'h0000_0000, 1'b0);
      issue("neg ovf",    32'hFF7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'hFF80_0000, 1'b1);
      drain();

      @(negedge clk);
      check("idle out_valid", {31'd0, out_valid}, 32'd0);
      check("idle result hold", result, 32'hFF80_0000);
      check("idle exception hold", {31'd0, Exception}, 32'd1);
      @(posedge clk);
      #1;

      // Reset while two operations are in flight.
      issue("pre-rst a", 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1);
      issue("pre-rst b", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("async rst out_valid", {31'd0, out_valid}, 32'd0);
      check("async rst result", result, 32'd0);
      check("async rst exception", {31'd0, Exception}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no stale out_valid", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      issue("post-rst 3-1", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
